// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the timing generator and pattern modules.
// 640x480 at 60 Hz with a 25 MHz pixel clock.
package vga_pkg;

    localparam int CW = 10;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FRONT_D  = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BACK_D   = 48;

    localparam int V_ACTIVE_D = 480;
    localparam int V_FRONT_D  = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BACK_D   = 33;

    localparam int H_TOTAL_D =
        H_ACTIVE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
    localparam int V_TOTAL_D =
        V_ACTIVE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
    localparam int FRAME_D = H_TOTAL_D * V_TOTAL_D;

endpackage

// File: rtl/vga_counter.sv
// Wrap counter: counts 0..MAX-1 while enabled, then returns to 0.
// Used once per axis by the timing generator.
module vga_counter
    import vga_pkg::*;
#(
    parameter int MAX = H_TOTAL_D
) (
    input  logic          clock25MHz,
    input  logic          reset,
    input  logic          en,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic at_last;

    assign at_last = (count == LAST);

    // advance on enable, wrap after the last value
    always_ff @(posedge clock25MHz) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            if (at_last) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel/line counters, visible-area flag and
// registered colour, syncs and frame marker with one cycle of latency.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FRONT  = H_FRONT_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BACK   = H_BACK_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FRONT  = V_FRONT_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BACK   = V_BACK_D,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clock25MHz,
    input  logic       reset,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       frame_start
);

    localparam int H_TOTAL =
        H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL =
        V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO  = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_HI  =
        CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_LO  = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_HI  =
        CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic line_end;
    logic hs_on;
    logic vs_on;
    logic origin;

    assign line_end = (x == H_LAST);

    vga_counter #(.MAX(H_TOTAL)) u_hcnt (
        .clock25MHz (clock25MHz),
        .reset      (reset),
        .en         (1'b1),
        .count      (x)
    );

    vga_counter #(.MAX(V_TOTAL)) u_vcnt (
        .clock25MHz (clock25MHz),
        .reset      (reset),
        .en         (line_end),
        .count      (y)
    );

    assign active = (x < H_VIS) && (y < V_VIS);
    assign hs_on  = (x >= HS_LO) && (x <= HS_HI);
    assign vs_on  = (y >= VS_LO) && (y <= VS_HI);
    assign origin = (x == '0) && (y == '0);

    // register every DAC-facing output from the same counter value
    always_ff @(posedge clock25MHz) begin
        if (!reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= !SYNC_POL;
            vga_vs      <= !SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= active ? red_in   : 4'h0;
            vga_g       <= active ? green_in : 4'h0;
            vga_b       <= active ? blue_in  : 4'h0;
            vga_hs      <= hs_on ? SYNC_POL : !SYNC_POL;
            vga_vs      <= vs_on ? SYNC_POL : !SYNC_POL;
            frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default build plus two builds with a
// short frame (27 lines) so full-frame behaviour fits in a short run.
module tb_vga_timing_generator;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        int   n;
        obs_t e;
    } vec_t;

    localparam logic [3:0] RIN = 4'hF;
    localparam logic [3:0] GIN = 4'hA;
    localparam logic [3:0] BIN = 4'h5;
    localparam logic [11:0] RGB = {RIN, GIN, BIN};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] red = RIN;
    logic [3:0] green = GIN;
    logic [3:0] blue = BIN;

    logic [9:0] x0, y0, xs, ys, xp, yp;
    logic act0, acts, actp;
    logic [3:0] r0, g0, b0, rs, gs, bs, rp, gp, bp;
    logic hs0, vs0, fs0, hss, vss, fss, hsp, vsp, fsp;

    obs_t o0, oS, oP;
    assign o0 = {x0, y0, act0, r0, g0, b0, hs0, vs0, fs0};
    assign oS = {xs, ys, acts, rs, gs, bs, hss, vss, fss};
    assign oP = {xp, yp, actp, rp, gp, bp, hsp, vsp, fsp};

    always #20 clk = ~clk;

    vga_timing_generator dut0 (
        .clock25MHz (clk), .reset (reset),
        .red_in (red), .green_in (green), .blue_in (blue),
        .x (x0), .y (y0), .active (act0),
        .vga_r (r0), .vga_g (g0), .vga_b (b0),
        .vga_hs (hs0), .vga_vs (vs0), .frame_start (fs0)
    );

    vga_timing_generator #(
        .V_ACTIVE (20), .V_FRONT (3), .V_SYNC (2), .V_BACK (2)
    ) duts (
        .clock25MHz (clk), .reset (reset),
        .red_in (red), .green_in (green), .blue_in (blue),
        .x (xs), .y (ys), .active (acts),
        .vga_r (rs), .vga_g (gs), .vga_b (bs),
        .vga_hs (hss), .vga_vs (vss), .frame_start (fss)
    );

    vga_timing_generator #(
        .V_ACTIVE (20), .V_FRONT (3), .V_SYNC (2), .V_BACK (2),
        .SYNC_POL (1'b1)
    ) dutp (
        .clock25MHz (clk), .reset (reset),
        .red_in (red), .green_in (green), .blue_in (blue),
        .x (xp), .y (yp), .active (actp),
        .vga_r (rp), .vga_g (gp), .vga_b (bp),
        .vga_hs (hsp), .vga_vs (vsp), .frame_start (fsp)
    );

    int checks = 0;
    int errors = 0;
    int mis0 = 0, misS = 0, misP = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t got,
                         input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic checki(input string name, input int got,
                          input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic obs_t mk(int cx, int cy, bit a,
                                logic [11:0] rgb,
                                bit hs, bit vs, bit fs);
        return {10'(cx), 10'(cy), a, rgb, hs, vs, fs};
    endfunction

    // n = clock edges since reset release (n >= 1); outputs show pixel n-1
    function automatic obs_t model(int n, int vact, int vfp, int vsw,
                                   int vtot, bit pol);
        int cx, cy, px, py;
        bit pa, h, v;
        cx = n % 800;
        cy = (n / 800) % vtot;
        px = (n - 1) % 800;
        py = ((n - 1) / 800) % vtot;
        pa = (px < 640) && (py < vact);
        h = (px >= 656) && (px <= 751);
        v = (py >= vact + vfp) && (py < vact + vfp + vsw);
        return mk(cx, cy, (cx < 640) && (cy < vact),
                  pa ? RGB : 12'h000,
                  h ? pol : !pol, v ? pol : !pol,
                  (px == 0) && (py == 0));
    endfunction

    task automatic cmp_model(input int n);
        obs_t e;
        e = model(n, 480, 10, 2, 525, 1'b0);
        if (o0 !== e) begin
            if (mis0 == 0)
                $display("dut0 first diff n=%0d got=%h exp=%h", n, o0, e);
            mis0++;
        end
        e = model(n, 20, 3, 2, 27, 1'b0);
        if (oS !== e) begin
            if (misS == 0)
                $display("duts first diff n=%0d got=%h exp=%h", n, oS, e);
            misS++;
        end
        e = model(n, 20, 3, 2, 27, 1'b1);
        if (oP !== e) begin
            if (misP == 0)
                $display("dutp first diff n=%0d got=%h exp=%h", n, oP, e);
            misP++;
        end
    endtask

    vec_t vec [12];

    initial begin
        obs_t rst0, rstp;
        int f0a, f0b, hs0low, fp1, hsphi;
        int vslo, vsfirst, vsphi, nfs, f2;
        int fsn [3];
        bit phs0, phsp, phss;

        vec[0]  = '{1,    mk(1,   0, 1, RGB,     1, 1, 1)};
        vec[1]  = '{2,    mk(2,   0, 1, RGB,     1, 1, 0)};
        vec[2]  = '{640,  mk(640, 0, 0, RGB,     1, 1, 0)};
        vec[3]  = '{641,  mk(641, 0, 0, 12'h000, 1, 1, 0)};
        vec[4]  = '{656,  mk(656, 0, 0, 12'h000, 1, 1, 0)};
        vec[5]  = '{657,  mk(657, 0, 0, 12'h000, 0, 1, 0)};
        vec[6]  = '{752,  mk(752, 0, 0, 12'h000, 0, 1, 0)};
        vec[7]  = '{753,  mk(753, 0, 0, 12'h000, 1, 1, 0)};
        vec[8]  = '{799,  mk(799, 0, 0, 12'h000, 1, 1, 0)};
        vec[9]  = '{800,  mk(0,   1, 1, 12'h000, 1, 1, 0)};
        vec[10] = '{801,  mk(1,   1, 1, RGB,     1, 1, 0)};
        vec[11] = '{1600, mk(0,   2, 1, 12'h000, 1, 1, 0)};

        rst0 = mk(0, 0, 1, 12'h000, 1, 1, 0);
        rstp = mk(0, 0, 1, 12'h000, 0, 0, 0);

        reset = 1'b0;
        repeat (3) step();
        check("reset_dut0", o0, rst0);
        check("reset_duts", oS, rst0);
        check("reset_dutp", oP, rstp);

        f0a = -1; f0b = -1; hs0low = 0; fp1 = -1; hsphi = 0;
        vslo = 0; vsfirst = -1; vsphi = 0; nfs = 0;
        fsn[0] = 0; fsn[1] = 0; fsn[2] = 0;
        phs0 = 1'b1; phsp = 1'b0;

        reset = 1'b1;
        for (int n = 1; n <= 55900; n++) begin
            step();
            cmp_model(n);
            for (int i = 0; i < 12; i++)
                if (vec[i].n == n)
                    check($sformatf("vec_n%0d", n), o0, vec[i].e);
            if (n <= 2410) begin
                if (phs0 && !o0.hs) begin
                    if (f0a < 0) f0a = n;
                    else if (f0b < 0) f0b = n;
                end
                if (!o0.hs && n <= 800) hs0low++;
                phs0 = o0.hs;
                if (!phsp && oP.hs && fp1 < 0) fp1 = n;
                if (oP.hs && n <= 800) hsphi++;
                phsp = oP.hs;
            end
            if (n <= 21600) begin
                if (!oS.vs) begin
                    vslo++;
                    if (vsfirst < 0) vsfirst = n;
                end
                if (oP.vs) vsphi++;
            end
            if (n <= 43205 && oS.fs) begin
                if (nfs < 3) fsn[nfs] = n;
                nfs++;
            end
        end

        checki("hs_first_fall", f0a, 657);
        checki("hs_low_width", hs0low, 96);
        checki("hs_period", f0b - f0a, 800);
        checki("pol_hs_rise", fp1, 657);
        checki("pol_hs_width", hsphi, 96);
        checki("vs_low_count", vslo, 1600);
        checki("vs_first_low", vsfirst, 18401);
        checki("pol_vs_count", vsphi, 1600);
        checki("fs_count", nfs, 3);
        checki("fs_first", fsn[0], 1);
        checki("fs_period1", fsn[1] - fsn[0], 21600);
        checki("fs_period2", fsn[2] - fsn[1], 21600);

        checki("pre_rst_hs", int'(oS.hs), 0);
        reset = 1'b0;
        step();
        check("midrst_dut0", o0, rst0);
        check("midrst_duts", oS, rst0);
        check("midrst_dutp", oP, rstp);
        repeat (2) step();
        check("midrst_hold", oS, rst0);

        reset = 1'b1;
        f2 = -1;
        phss = 1'b1;
        for (int n = 1; n <= 1700; n++) begin
            step();
            cmp_model(n);
            if (n == 1)
                check("restart_duts", oS, model(1, 20, 3, 2, 27, 1'b0));
            if (phss && !oS.hs && f2 < 0) f2 = n;
            phss = oS.hs;
        end
        checki("restart_hs_fall", f2, 657);

        checki("model_dut0", mis0, 0);
        checki("model_duts", misS, 0);
        checki("model_dutp", misP, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-004 SHALL have parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-008 SHALL have parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-010 SHALL have port clock25MHz, input, 1 bit: pixel clock, the only clock in the block.
REQ-011 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-012 SHALL have port x, output, 10 bits: current horizontal pixel count.
REQ-013 SHALL have port y, output, 10 bits: current line count.
REQ-014 SHALL have port active, output, 1 bit: high when (x,y) lies in the visible area.
REQ-015 SHALL have ports red_in, green_in and blue_in, each input, 4 bits: pattern colour for the current (x,y).
REQ-016 SHALL have ports vga_r, vga_g and vga_b, each output, 4 bits: registered colour to the DAC.
REQ-017 SHALL have ports vga_hs and vga_vs, each output, 1 bit: registered horizontal and vertical sync.
REQ-018 SHALL have port frame_start, output, 1 bit: one-cycle pulse aligned with output pixel (0,0).

Function
REQ-019 SHALL define H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 SHALL increment the horizontal counter every clock, wrapping from H_TOTAL-1 to 0.
REQ-021 SHALL increment the vertical counter only on horizontal wrap, wrapping from V_TOTAL-1 to 0 in the same cycle the horizontal counter wraps.
REQ-022 SHALL drive x and y directly from the counters, unmodified, including during blanking (x 0..799, y 0..524).
REQ-023 SHALL drive active combinationally as (x < H_ACTIVE) AND (y < V_ACTIVE).
REQ-024 SHALL treat red_in, green_in and blue_in as a combinational function of x and y in the same cycle.
REQ-025 SHALL register vga_r, vga_g and vga_b one cycle after the counter value, each forced to 0 when active was low.
REQ-026 SHALL assert vga_hs (level SYNC_POL) one cycle after counter x is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] = [656,751], and deassert it otherwise.
REQ-027 SHALL assert vga_vs (level SYNC_POL) one cycle after counter y is in [490,491], for entire lines, and deassert it otherwise.
REQ-028 SHALL register frame_start high for exactly one cycle, one cycle after counters are (0,0).
REQ-029 SHALL give all VGA outputs the same one-cycle latency, so colour, syncs and frame_start stay mutually aligned.
REQ-030 SHALL have a line period of exactly H_TOTAL clocks and a frame period of exactly H_TOTAL*V_TOTAL = 420000 clocks.

Reset
REQ-031 SHALL, while reset is low at a clock edge, set both counters to 0, vga_r/g/b to 0, vga_hs and vga_vs to the deasserted level (!SYNC_POL), and frame_start to 0.
REQ-032 SHALL, when reset is asserted mid-line or mid-frame, abandon the current frame with no partial sync pulse continuing past the reset edge.
REQ-033 SHALL count (1,0) on the first clock after reset release, and pulse frame_start on that same edge (registered from (0,0)).

Structure
REQ-034 SHALL place the timing defaults and the derived totals as constants in the shared vga package, so they are shared with the pattern modules.
REQ-035 SHALL contain at most one sub-module, vga_counter: a parameterised wrap counter with an enable input, instantiated twice (horizontal, vertical).

Verification
REQ-036 SHALL verify reset release: frame_start pulses 1 cycle after release; next frame_start follows exactly 420000 cycles later.
REQ-037 SHALL verify horizontal timing: vga_hs low for 96 consecutive cycles starting 657 cycles after the line start (x=0 edge), period 800.
REQ-038 SHALL verify vertical timing: vga_vs low for exactly 1600 cycles per frame, starting when y=490, x=0 plus 1 cycle.
REQ-039 SHALL verify blanking: with red_in/green_in/blue_in tied to 4'hF, vga_r=F for x 0..639 and 0 for x 640..799, one cycle delayed; all 0 for y >= 480.
REQ-040 SHALL verify mid-frame reset: assert reset at x=700, y=300 for 3 cycles; outputs reach their reset values on the first edge, and counting restarts from (0,0).
REQ-041 SHALL verify the SYNC_POL=1 build: the sync pulses are inverted, with identical timing.
